lemming_world: RTL and testbench
================================

LEMMING_WORLD -- requirements
Module: lemming_world

Interface
REQ-001 SHALL have parameter DIG_CYCLES, default 4: consecutive digging cycles needed to remove one ground level (range 1..15).
REQ-002 SHALL have parameter FALL_DIV, default 4: falling cycles per one level of descent (range 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: `clk  in  1  rising-edge clock`.
REQ-004 `areset  in  1  asynchronous, active-high reset`.
REQ-005 `walk_left  in  1  lemming walking-left indication, from the lemming FSM`.
REQ-006 `walk_right  in  1  lemming walking-right indication`.
REQ-007 `aaah  in  1  lemming falling indication`.
REQ-008 `digging  in  1  lemming digging indication`.
REQ-009 `load_en  in  1  terrain write strobe`.
REQ-010 `load_col  in  4  column to write`.
REQ-011 `load_depth  in  3  floor depth to write (0 = top, 7 = bedrock)`.
REQ-012 `ground  out  1  lemming is standing on floor`.
REQ-013 `bump_left  out  1  wall directly left of the lemming`.
REQ-014 `bump_right  out  1  wall directly right of the lemming`.
REQ-015 `pos_x  out  4  lemming column`.
REQ-016 `pos_y  out  3  lemming depth`.

Function
REQ-017 SHALL hold 16 column floor depths D[0..15], 3 bits each; a larger D is deeper.
REQ-018 SHALL drive all outputs combinationally from registered state only; no input-to-output path.
REQ-019 SHALL compute ground = (pos_y >= D[pos_x]).
REQ-020 SHALL assert bump_left when pos_x==0 (non-wrap build) or D[pos_x-1] < pos_y; bump_right is symmetric with pos_x==15 and D[pos_x+1].
REQ-021 SHALL set pos_x <= pos_x-1 at the clock edge when walk_left && !walk_right && ground && !bump_left; rightward motion is symmetric.
REQ-022 SHALL hold pos_x when walk_left and walk_right are both high.
REQ-023 Fall: SHALL advance a fall sub-counter while aaah && pos_y < D[pos_x]; at FALL_DIV-1 it SHALL increment pos_y and clear the counter; otherwise the counter SHALL be held at 0.
REQ-024 Dig: SHALL advance a dig counter while digging && ground && D[pos_x] < 7; at DIG_CYCLES-1 it SHALL increment D[pos_x] and clear the counter; otherwise the counter SHALL be held at 0; D==7 (bedrock) is never dug.
REQ-025 SHALL, when D[pos_x] < pos_y (floor loaded above the lemming), set pos_y <= D[pos_x] on the next edge.
REQ-026 load_en SHALL write D[load_col] <= load_depth, visible the next cycle.
REQ-027 A load to pos_x in the same cycle as a dig completion SHALL win, and the dig counter SHALL clear.
REQ-028 Motion, fall and dig SHALL be evaluated from pre-edge values; at most one of them takes effect per edge.

Reset
REQ-029 areset SHALL immediately set D[*]=0, pos_x=0, pos_y=0 and both counters to 0.
REQ-030 Outputs in reset SHALL be: ground=1, bump_left=1 (non-wrap build), bump_right=0, pos_x=0, pos_y=0.
REQ-031 Reset asserted mid-fall or mid-dig SHALL discard all progress.

Configuration
REQ-032 With LEMMING_WORLD_WRAP_EN defined, columns SHALL form a ring (15 is adjacent to 0); the edge terms of REQ-020 are removed and pos_x wraps modulo 16.
REQ-033 Without LEMMING_WORLD_WRAP_EN, columns 0 and 15 SHALL be bounded by permanent walls.

Structure
REQ-034 Package lemming_pkg SHALL hold NCOLS=16, DEPTH_W=3, BEDROCK=7 and the column/depth typedefs.
REQ-035 Sub-module lemming_terrain SHALL be the 16x3 register file, with one write port (load/dig, load priority) and three read ports (x-1, x, x+1).

Verification
REQ-036 Reset, then hold walk_right=1 on flat terrain: pos_x SHALL step 0→15 in 15 cycles, after which bump_right=1 (non-wrap build).
REQ-037 Load D[3]=0 and D[4]=5, with the lemming at x=3 walking right: pos_x SHALL become 4, ground=0; with aaah=1, pos_y SHALL reach 5 after 20 cycles, then ground=1.
REQ-038 Load D[5]=0 and set pos_y=2 at x=4: bump_right=1, and walk_right SHALL NOT change pos_x.
REQ-039 Hold digging=1 at x=0 with D[0]=0: D[0] SHALL become 1 after 4 cycles and ground SHALL drop to 0; with D[0]=7, digging SHALL leave ground=1 indefinitely.
REQ-040 Assert areset during the 3rd fall cycle at y=2: pos_x and pos_y SHALL go to 0 and all D to 0 without waiting for a clock edge.
REQ-041 In the wrap build, walk_left at x=0 on flat terrain SHALL give pos_x=15 and bump_left=0.

Source files
------------

// File: rtl/lemming_pkg.sv
// Shared sizes and types for the lemming world slice.
// LEMMING_WORLD_WRAP_EN (when defined) turns the column range into a ring.
package lemming_pkg;

  localparam int unsigned NCOLS   = 16;
  localparam int unsigned DEPTH_W = 3;

  typedef logic [3:0]         col_t;
  typedef logic [DEPTH_W-1:0] depth_t;
  typedef logic [3:0]         cnt_t;

  localparam depth_t BEDROCK = 3'd7;

  // Which single update the next clock edge applies.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_SNAP,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_FALL,
    ACT_DIG
  } act_t;

endpackage

// File: rtl/lemming_terrain.sv
// 16-entry floor-depth register file: one write port (load beats dig),
// three read ports around the lemming column.
module lemming_terrain
  import lemming_pkg::*;
(
  input  logic   clk,
  input  logic   areset,
  input  logic   i_load_en,
  input  col_t   i_load_col,
  input  depth_t i_load_depth,
  input  logic   i_dig_en,
  input  col_t   i_x,
  output depth_t o_d_left,
  output depth_t o_d_here,
  output depth_t o_d_right
);

  depth_t r_d [NCOLS];
  col_t   w_xl;
  col_t   w_xr;

  // Neighbour indices wrap mod 16; the top level masks the edges when bounded.
  assign w_xl = i_x - 4'd1;
  assign w_xr = i_x + 4'd1;

  assign o_d_left  = r_d[w_xl];
  assign o_d_here  = r_d[i_x];
  assign o_d_right = r_d[w_xr];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < NCOLS; i++) begin
        r_d[i] <= '0;
      end
    end else if (i_load_en) begin
      r_d[i_load_col] <= i_load_depth;
    end else if (i_dig_en) begin
      r_d[i_x] <= r_d[i_x] + 3'd1;
    end
  end

endmodule

// File: rtl/lemming_world.sv
// Lemming world: terrain, position, fall and dig progress around a lemming FSM.
// Build option: LEMMING_WORLD_WRAP_EN makes columns 0 and 15 adjacent.
module lemming_world
  import lemming_pkg::*;
#(
  parameter int unsigned DIG_CYCLES = 4,
  parameter int unsigned FALL_DIV   = 4
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       walk_left,
  input  logic       walk_right,
  input  logic       aaah,
  input  logic       digging,
  input  logic       load_en,
  input  logic [3:0] load_col,
  input  logic [2:0] load_depth,
  output logic       ground,
  output logic       bump_left,
  output logic       bump_right,
  output logic [3:0] pos_x,
  output logic [2:0] pos_y
);

  localparam cnt_t FALL_LAST = cnt_t'(FALL_DIV - 1);
  localparam cnt_t DIG_LAST  = cnt_t'(DIG_CYCLES - 1);

  col_t   r_x;
  depth_t r_y;
  cnt_t   r_fall_cnt;
  cnt_t   r_dig_cnt;

  depth_t w_d_left;
  depth_t w_d_here;
  depth_t w_d_right;
  logic   w_ground;
  logic   w_bump_l;
  logic   w_bump_r;
  logic   w_dig_done;
  act_t   w_act;

  lemming_terrain u_terrain (
    .clk          (clk),
    .areset       (areset),
    .i_load_en    (load_en),
    .i_load_col   (load_col),
    .i_load_depth (load_depth),
    .i_dig_en     (w_dig_done),
    .i_x          (r_x),
    .o_d_left     (w_d_left),
    .o_d_here     (w_d_here),
    .o_d_right    (w_d_right)
  );

  assign w_ground = (r_y >= w_d_here);

`ifdef LEMMING_WORLD_WRAP_EN
  assign w_bump_l = (w_d_left < r_y);
  assign w_bump_r = (w_d_right < r_y);
`else
  assign w_bump_l = (r_x == 4'd0)  || (w_d_left < r_y);
  assign w_bump_r = (r_x == 4'd15) || (w_d_right < r_y);
`endif

  // Snap and motion need ground, falling needs its absence, so priority
  // only matters between snap, motion and dig.
  always_comb begin
    w_act = ACT_NONE;
    if (w_d_here < r_y) begin
      w_act = ACT_SNAP;
    end else if (walk_left && !walk_right && w_ground && !w_bump_l) begin
      w_act = ACT_LEFT;
    end else if (walk_right && !walk_left && w_ground && !w_bump_r) begin
      w_act = ACT_RIGHT;
    end else if (aaah && !w_ground) begin
      w_act = ACT_FALL;
    end else if (digging && w_ground && (w_d_here < BEDROCK)) begin
      w_act = ACT_DIG;
    end
  end

  assign w_dig_done = (w_act == ACT_DIG) && (r_dig_cnt == DIG_LAST);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_fall_cnt <= '0;
      r_dig_cnt  <= '0;
    end else begin
      r_fall_cnt <= '0;
      r_dig_cnt  <= '0;
      case (w_act)
        ACT_SNAP:  r_y <= w_d_here;
        ACT_LEFT:  r_x <= r_x - 4'd1;
        ACT_RIGHT: r_x <= r_x + 4'd1;
        ACT_FALL: begin
          if (r_fall_cnt == FALL_LAST) begin
            r_y <= r_y + 3'd1;
          end else begin
            r_fall_cnt <= r_fall_cnt + 4'd1;
          end
        end
        ACT_DIG: begin
          if (r_dig_cnt != DIG_LAST) begin
            r_dig_cnt <= r_dig_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ground     = w_ground;
  assign bump_left  = w_bump_l;
  assign bump_right = w_bump_r;
  assign pos_x      = r_x;
  assign pos_y      = r_y;

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world (default DIG_CYCLES=4, FALL_DIV=4).
// Honours LEMMING_WORLD_WRAP_EN for the edge-column expectations.
module tb_lemming_world;

  typedef struct {
    logic       ld;
    logic [3:0] col;
    logic [2:0] dep;
    logic       wl;
    logic       wr;
    logic       aa;
    logic       dg;
    logic       g;
    logic       bl;
    logic       br;
    logic [3:0] x;
    logic [2:0] y;
  } vec_t;

`ifdef LEMMING_WORLD_WRAP_EN
  localparam logic BL0  = 1'b0;
  localparam logic WRAP = 1'b1;
`else
  localparam logic BL0  = 1'b1;
  localparam logic WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       walk_left = 1'b0;
  logic       walk_right = 1'b0;
  logic       aaah = 1'b0;
  logic       digging = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_col = '0;
  logic [2:0] load_depth = '0;
  logic       ground;
  logic       bump_left;
  logic       bump_right;
  logic [3:0] pos_x;
  logic [2:0] pos_y;

  int n_vec = 0;
  int n_err = 0;

  vec_t tab_a [6];
  vec_t tab_b [9];

  lemming_world #(.DIG_CYCLES(4), .FALL_DIV(4)) dut (
    .clk        (clk),
    .areset     (areset),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .load_en    (load_en),
    .load_col   (load_col),
    .load_depth (load_depth),
    .ground     (ground),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .pos_x      (pos_x),
    .pos_y      (pos_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [3:0] col, input logic [2:0] dep,
                              input logic wl, input logic wr, input logic aa, input logic dg,
                              input logic g, input logic bl, input logic br,
                              input logic [3:0] x, input logic [2:0] y);
    vec_t v;
    v.ld = ld; v.col = col; v.dep = dep; v.wl = wl; v.wr = wr; v.aa = aa; v.dg = dg;
    v.g = g; v.bl = bl; v.br = br; v.x = x; v.y = y;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic [3:0] col, input logic [2:0] dep,
                       input logic wl, input logic wr, input logic aa, input logic dg);
    load_en = ld; load_col = col; load_depth = dep;
    walk_left = wl; walk_right = wr; aaah = aa; digging = dg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    drive(v.ld, v.col, v.dep, v.wl, v.wr, v.aa, v.dg);
    step();
    chk($sformatf("%s[%0d].ground", tag, idx), {7'd0, ground}, {7'd0, v.g});
    chk($sformatf("%s[%0d].bump_left", tag, idx), {7'd0, bump_left}, {7'd0, v.bl});
    chk($sformatf("%s[%0d].bump_right", tag, idx), {7'd0, bump_right}, {7'd0, v.br});
    chk($sformatf("%s[%0d].pos_x", tag, idx), {4'd0, pos_x}, {4'd0, v.x});
    chk($sformatf("%s[%0d].pos_y", tag, idx), {5'd0, pos_y}, {5'd0, v.y});
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    #1;
  endtask

  initial begin
    //             ld col  dep wl wr aa dg   g  bl   br  x     y
    tab_a[0] = mk(1, 4'd3, 3'd0, 0, 0, 0, 0, 1, BL0, 0, 4'd0, 3'd0);
    tab_a[1] = mk(1, 4'd4, 3'd5, 0, 0, 0, 0, 1, BL0, 0, 4'd0, 3'd0);
    tab_a[2] = mk(0, 4'd0, 3'd0, 0, 1, 0, 0, 1, 0,   0, 4'd1, 3'd0);
    tab_a[3] = mk(0, 4'd0, 3'd0, 0, 1, 0, 0, 1, 0,   0, 4'd2, 3'd0);
    tab_a[4] = mk(0, 4'd0, 3'd0, 0, 1, 0, 0, 1, 0,   0, 4'd3, 3'd0);
    tab_a[5] = mk(0, 4'd0, 3'd0, 0, 1, 0, 0, 0, 0,   0, 4'd4, 3'd0);
    // Lemming at x=4, y=5 with D[3]=0, D[4]=5, D[5]=0.
    tab_b[0] = mk(1, 4'd4, 3'd2, 0, 0, 0, 0, 1, 1, 1, 4'd4, 3'd5);
    tab_b[1] = mk(0, 4'd0, 3'd0, 0, 0, 0, 0, 1, 1, 1, 4'd4, 3'd2);
    tab_b[2] = mk(0, 4'd0, 3'd0, 0, 1, 0, 0, 1, 1, 1, 4'd4, 3'd2);
    tab_b[3] = mk(0, 4'd0, 3'd0, 1, 1, 0, 0, 1, 1, 1, 4'd4, 3'd2);
    tab_b[4] = mk(0, 4'd0, 3'd0, 1, 0, 0, 0, 1, 1, 1, 4'd4, 3'd2);
    tab_b[5] = mk(1, 4'd3, 3'd2, 0, 0, 0, 0, 1, 0, 1, 4'd4, 3'd2);
    tab_b[6] = mk(0, 4'd0, 3'd0, 1, 0, 0, 0, 1, 1, 0, 4'd3, 3'd2);
    tab_b[7] = mk(0, 4'd0, 3'd0, 0, 1, 0, 0, 1, 0, 1, 4'd4, 3'd2);
    tab_b[8] = mk(0, 4'd0, 3'd0, 0, 0, 1, 0, 1, 0, 1, 4'd4, 3'd2);

    // Reset outputs, sampled before the first clock edge.
    #2;
    chk("rst.ground", {7'd0, ground}, 8'd1);
    chk("rst.bump_left", {7'd0, bump_left}, {7'd0, BL0});
    chk("rst.bump_right", {7'd0, bump_right}, 8'd0);
    chk("rst.pos_x", {4'd0, pos_x}, 8'd0);
    chk("rst.pos_y", {5'd0, pos_y}, 8'd0);
    do_reset();

    // Walk right across flat terrain.
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("walk_r.x%0d", i), {4'd0, pos_x}, 8'(i));
    end
    chk("walk_r.bump_right15", {7'd0, bump_right}, {7'd0, ~WRAP});
    step();
    chk("walk_r.edge_x", {4'd0, pos_x}, WRAP ? 8'd0 : 8'd15);

    // Walk left from column 0.
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    chk("walk_l0.pos_x", {4'd0, pos_x}, WRAP ? 8'd15 : 8'd0);
    chk("walk_l0.bump_left", {7'd0, bump_left}, WRAP ? 8'd0 : 8'd1);

    // Step into a pit, fall 20 cycles to y=5, then snap/bump cases.
    do_reset();
    for (int i = 0; i < 6; i++) apply_vec("pit", i, tab_a[i]);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("fall.y%0d", i), {5'd0, pos_y}, 8'(i / 4));
      chk($sformatf("fall.g%0d", i), {7'd0, ground}, (i / 4 >= 5) ? 8'd1 : 8'd0);
    end
    for (int i = 0; i < 9; i++) apply_vec("ledge", i, tab_b[i]);

    // Dig through one level in 4 cycles.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("dig.g%0d", i), {7'd0, ground}, (i < 4) ? 8'd1 : 8'd0);
    end
    // Bedrock column: fall to 7, then digging never removes it.
    drive(1, 4'd0, 3'd7, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 28; i++) step();
    chk("bedrock.y", {5'd0, pos_y}, 8'd7);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("bedrock.g%0d", i), {7'd0, ground}, 8'd1);
    end

    // Load to the dug column on the dig-completion edge wins.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step();
    drive(1, 4'd0, 3'd3, 0, 0, 0, 1);
    step();
    chk("collide.ground", {7'd0, ground}, 8'd0);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step();
    chk("collide.y", {5'd0, pos_y}, 8'd3);
    chk("collide.g", {7'd0, ground}, 8'd1);

    // Asynchronous reset during the 3rd fall cycle at y=2.
    do_reset();
    drive(1, 4'd1, 3'd5, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 4'd0, 3'd3, 0, 0, 0, 0);
    step();
    chk("midfall.x", {4'd0, pos_x}, 8'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step();
    chk("midfall.y", {5'd0, pos_y}, 8'd2);
    areset = 1'b1;
    #1;
    chk("arst.pos_x", {4'd0, pos_x}, 8'd0);
    chk("arst.pos_y", {5'd0, pos_y}, 8'd0);
    chk("arst.ground", {7'd0, ground}, 8'd1);
    chk("arst.bump_right", {7'd0, bump_right}, 8'd0);
    step();
    areset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("arst.flat_y", {5'd0, pos_y}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
